// File: rtl/rule_set_pkg.sv
// Shared rule-ID set types and set/bitmap conversion helpers for the
// per-field match trees and the intersect stage.
package rule_set_pkg;

  localparam int NUM_RULE_ID   = 8;
  localparam int RULE_ID_WIDTH = 3;
  localparam int SLOT_WIDTH    = 1 + RULE_ID_WIDTH;
  localparam int SET_WIDTH     = NUM_RULE_ID * SLOT_WIDTH;

  typedef logic [0:SET_WIDTH-1]     rule_set_t;
  typedef logic [NUM_RULE_ID-1:0]   rule_bitmap_t;
  typedef logic [RULE_ID_WIDTH-1:0] rule_id_t;

  // Invalid slots are skipped whatever their ID bits; duplicates simply OR.
  function automatic rule_bitmap_t set_to_bitmap(input rule_set_t s);
    rule_bitmap_t bm;
    rule_id_t     id;
    bm = '0;
    for (int k = 0; k < NUM_RULE_ID; k++) begin
      id = s[k*SLOT_WIDTH+1 +: RULE_ID_WIDTH];
      if (s[k*SLOT_WIDTH]) bm[id] = 1'b1;
    end
    return bm;
  endfunction

  // Fills from the last slot downward so IDs end up ascending and right-justified.
  function automatic rule_set_t bitmap_to_set(input rule_bitmap_t bm);
    rule_set_t s;
    int        slot;
    s    = '0;
    slot = NUM_RULE_ID - 1;
    for (int r = NUM_RULE_ID - 1; r >= 0; r--) begin
      if (bm[r]) begin
        s[slot*SLOT_WIDTH +: SLOT_WIDTH] = {1'b1, rule_id_t'(r)};
        slot--;
      end
    end
    return s;
  endfunction

  function automatic rule_id_t lowest_id(input rule_bitmap_t bm);
    rule_id_t id;
    id = '0;
    for (int r = NUM_RULE_ID - 1; r >= 0; r--) begin
      if (bm[r]) id = rule_id_t'(r);
    end
    return id;
  endfunction

endpackage

// File: rtl/rule_set_fifo.sv
// Small occupancy-counted FIFO for one field's rule-ID sets; drops pushes
// when full unless a pop frees a slot on the same edge.
module rule_set_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [0:WIDTH-1] din,
  output logic [0:WIDTH-1] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [0:WIDTH-1] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rule_set_intersect.sv
// Pairs SIP and DIP rule-ID sets in arrival order, ANDs them and reports the
// intersected set plus the lowest (highest-priority) matching rule ID.
module rule_set_intersect
  import rule_set_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sip_valid,
  input  logic [0:SET_WIDTH-1]     sip_set,
  input  logic                     dip_valid,
  input  logic [0:SET_WIDTH-1]     dip_set,
  output logic                     out_valid,
  output logic [0:SET_WIDTH-1]     out_set,
  output logic                     out_match_valid,
  output logic [RULE_ID_WIDTH-1:0] out_match_id,
  output logic                     sip_overflow,
  output logic                     dip_overflow
);

  rule_set_t    sip_head;
  rule_set_t    dip_head;
  logic         sip_full;
  logic         dip_full;
  logic         sip_empty;
  logic         dip_empty;
  logic         pop;
  logic         s1_valid;
  rule_bitmap_t s1_and;
  logic         unused_full;

  assign pop         = !sip_empty && !dip_empty;
  assign unused_full = sip_full ^ dip_full;

  rule_set_fifo #(.WIDTH(SET_WIDTH), .DEPTH(FIFO_DEPTH)) u_sip_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (sip_valid),
    .pop      (pop),
    .din      (sip_set),
    .head     (sip_head),
    .full     (sip_full),
    .empty    (sip_empty),
    .overflow (sip_overflow)
  );

  rule_set_fifo #(.WIDTH(SET_WIDTH), .DEPTH(FIFO_DEPTH)) u_dip_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (dip_valid),
    .pop      (pop),
    .din      (dip_set),
    .head     (dip_head),
    .full     (dip_full),
    .empty    (dip_empty),
    .overflow (dip_overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_and   <= '0;
    end else begin
      s1_valid <= pop;
      s1_and   <= pop ? (set_to_bitmap(sip_head) & set_to_bitmap(dip_head)) : '0;
    end
  end

  // Payload outputs are forced to zero whenever out_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_set         <= '0;
      out_match_valid <= 1'b0;
      out_match_id    <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_set         <= bitmap_to_set(s1_and);
        out_match_valid <= |s1_and;
        out_match_id    <= lowest_id(s1_and);
      end else begin
        out_set         <= '0;
        out_match_valid <= 1'b0;
        out_match_id    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rule_set_intersect.sv
// Self-checking bench for rule_set_intersect: directed cases plus random
// traffic against a queue-based reference model of the pairing and AND.
module tb_rule_set_intersect;

  logic        clk;
  logic        reset;
  logic        sip_valid;
  logic [0:31] sip_set;
  logic        dip_valid;
  logic [0:31] dip_set;
  logic        out_valid;
  logic [0:31] out_set;
  logic        out_match_valid;
  logic [2:0]  out_match_id;
  logic        sip_overflow;
  logic        dip_overflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] sq[$];
  logic [31:0] dq[$];
  logic        p_valid, e_valid;
  logic [31:0] p_set, e_set;
  logic        p_mv, e_mv;
  logic [2:0]  p_id, e_id;
  logic        e_sovf, e_dovf;

  rule_set_intersect #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .sip_valid       (sip_valid),
    .sip_set         (sip_set),
    .dip_valid       (dip_valid),
    .dip_set         (dip_set),
    .out_valid       (out_valid),
    .out_set         (out_set),
    .out_match_valid (out_match_valid),
    .out_match_id    (out_match_id),
    .sip_overflow    (sip_overflow),
    .dip_overflow    (dip_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Slot k is nibble (7-k) counted from the right; IDs of both sets are
  // collected as membership flags and rebuilt as an ascending list.
  function automatic void isect(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output logic mv,
                                output logic [2:0] id);
    bit ma[8];
    bit mb[8];
    int na, nb, first;
    for (int k = 0; k < 8; k++) begin
      na = int'((a >> (4 * (7 - k))) & 32'hF);
      nb = int'((b >> (4 * (7 - k))) & 32'hF);
      if (na >= 8) ma[na - 8] = 1'b1;
      if (nb >= 8) mb[nb - 8] = 1'b1;
    end
    s = 32'h0;
    first = -1;
    for (int r = 0; r < 8; r++) begin
      if (ma[r] && mb[r]) begin
        s = (s << 4) | 32'(8 + r);
        if (first < 0) first = r;
      end
    end
    mv = (first >= 0);
    id = mv ? 3'(first) : 3'd0;
  endfunction

  function automatic logic [31:0] rand_set();
    logic [31:0] s;
    int n;
    s = 32'h0;
    n = 0;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = (s << 4) | 32'(8 + r);
        n++;
      end
    end
    if (n > 0 && n < 8 && $urandom_range(0, 3) == 0) s = (s << 4) | (s & 32'hF);
    return s;
  endfunction

  task automatic model_reset();
    sq.delete();
    dq.delete();
    p_valid = 0; p_set = 0; p_mv = 0; p_id = 0;
    e_valid = 0; e_set = 0; e_mv = 0; e_id = 0;
    e_sovf = 0; e_dovf = 0;
  endtask

  // Drive one cycle of stimulus, advance the model over the edge, sample at +1.
  task automatic tick(input logic sv, input logic [31:0] s,
                      input logic dv, input logic [31:0] d);
    bit do_pop;
    logic [31:0] a, b;
    sip_valid = sv; sip_set = s;
    dip_valid = dv; dip_set = d;
    @(posedge clk);
    do_pop = (sq.size() > 0) && (dq.size() > 0);
    e_valid = p_valid;
    e_set   = p_valid ? p_set : 32'h0;
    e_mv    = p_valid ? p_mv : 1'b0;
    e_id    = p_valid ? p_id : 3'd0;
    p_valid = do_pop;
    if (do_pop) begin
      a = sq.pop_front();
      b = dq.pop_front();
      isect(a, b, p_set, p_mv, p_id);
    end
    if (sv) begin
      if (sq.size() < 4) sq.push_back(s);
      else e_sovf = 1'b1;
    end
    if (dv) begin
      if (dq.size() < 4) dq.push_back(d);
      else e_dovf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sip_valid = 0; sip_set = 0; dip_valid = 0; dip_set = 0;
    model_reset();
    #3;
    total++;
    if ({out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow} !== 38'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b want all zero",
               out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] sv[3];
    logic [31:0] dv[3];
    logic [31:0] xs[3];
    logic        xm[3];
    logic [2:0]  xi[3];
    sv = '{32'h0000ADEF, 32'h0089BDEF, 32'h0000000A};
    dv = '{32'h000000EF, 32'h000009CD, 32'h0000000B};
    xs = '{32'h000000EF, 32'h0000009D, 32'h00000000};
    xm = '{1'b1, 1'b1, 1'b0};
    xi = '{3'd6, 3'd1, 3'd0};
    for (int i = 0; i < 3; i++) begin
      tick(1, sv[i], 1, dv[i]);
      tick(0, 0, 0, 0);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL directed%0d_early: out_valid got %0b want 0", i, out_valid);
      end
      tick(0, 0, 0, 0);
      total++;
      if ({out_valid, out_set, out_match_valid, out_match_id} !== {1'b1, xs[i], xm[i], xi[i]}) begin
        bad++;
        $display("FAIL directed%0d: got v=%0b set=%h mv=%0b id=%0d want v=1 set=%h mv=%0b id=%0d",
                 i, out_valid, out_set, out_match_valid, out_match_id, xs[i], xm[i], xi[i]);
      end
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s[3];
    logic [31:0] d[3];
    int outs;
    outs = 0;
    for (int i = 0; i < 3; i++) begin
      s[i] = rand_set();
      d[i] = rand_set();
    end
    for (int c = 0; c < 9; c++) begin
      tick(c < 3, (c < 3) ? s[c % 3] : 32'h0, (c >= 3 && c < 6), (c >= 3 && c < 6) ? d[c % 3] : 32'h0);
      if (out_valid) outs++;
      total++;
      if ({out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow} !==
          {e_valid, e_set, e_mv, e_id, e_sovf, e_dovf} || out_valid !== (c >= 5 && c < 8)) begin
        bad++;
        $display("FAIL back_to_back c=%0d: got v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b want v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b",
                 c, out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow,
                 e_valid, e_set, e_mv, e_id, e_sovf, e_dovf);
      end
    end
    total++;
    if (outs != 3) begin
      bad++;
      $display("FAIL back_to_back_count: got %0d outputs want 3", outs);
    end
  endtask

  task automatic test_overflow();
    int outs;
    outs = 0;
    for (int c = 0; c < 5; c++) tick(1, rand_set(), 0, 0);
    total++;
    if (sip_overflow !== 1'b1 || dip_overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_set: got sip=%0b dip=%0b want sip=1 dip=0", sip_overflow, dip_overflow);
    end
    for (int c = 0; c < 7; c++) begin
      tick(0, 0, c < 4, (c < 4) ? rand_set() : 32'h0);
      if (out_valid) outs++;
      total++;
      if ({out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow} !==
          {e_valid, e_set, e_mv, e_id, e_sovf, e_dovf}) begin
        bad++;
        $display("FAIL overflow_drain c=%0d: got v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b want v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b",
                 c, out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow,
                 e_valid, e_set, e_mv, e_id, e_sovf, e_dovf);
      end
    end
    total++;
    if (outs != 4 || sip_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_pairs: got outputs=%0d sip_ovf=%0b want outputs=4 sip_ovf=1", outs, sip_overflow);
    end
  endtask

  task automatic test_reset_midop();
    tick(1, 32'h0000ADEF, 1, 32'h000000EF);
    tick(1, 32'h0089BDEF, 1, 32'h000009CD);
    tick(0, 0, 0, 0);
    total++;
    if (out_valid !== e_valid || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midop_before: out_valid got %0b want 1", out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow} !== 38'h0) begin
      bad++;
      $display("FAIL midop_reset: got v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b want all zero",
               out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      tick(0, 0, c == 3, (c == 3) ? 32'h0000000F : 32'h0);
      total++;
      if ({out_valid, out_set, out_match_valid, out_match_id} !== 38'h0 >> 6 || out_valid !== e_valid) begin
        bad++;
        $display("FAIL midop_stale c=%0d: got v=%0b set=%h want v=0 set=0", c, out_valid, out_set);
      end
    end
  endtask

  task automatic test_random();
    logic sv, dv;
    for (int c = 0; c < 400; c++) begin
      sv = ($urandom_range(0, 99) < 55);
      dv = ($urandom_range(0, 99) < 50);
      tick(sv, sv ? rand_set() : 32'h0, dv, dv ? rand_set() : 32'h0);
      total++;
      if ({out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow} !==
          {e_valid, e_set, e_mv, e_id, e_sovf, e_dovf}) begin
        bad++;
        $display("FAIL random c=%0d: got v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b want v=%0b set=%h mv=%0b id=%0d ovf=%0b%0b",
                 c, out_valid, out_set, out_match_valid, out_match_id, sip_overflow, dip_overflow,
                 e_valid, e_set, e_mv, e_id, e_sovf, e_dovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rule_set_intersect.md
Name: rule_set_intersect

Overview:
- Downstream stage of the per-field prefix-match trees. It consumes the ordered rule ID set from the SIP tree and the one from the DIP tree.
- The two trees have different pipeline depths, so their results can arrive on different cycles. Per-field FIFOs pair the SIP and DIP results for the same packet in arrival order.
- The block ANDs the two sets and emits the intersected set plus the highest-priority (lowest) matching rule ID.
- Feeds the final action lookup.

Parameters:
- NUM_RULE_ID, 8, number of rules in the rule set.
- RULE_ID_WIDTH, 3, bits per rule ID (log2 NUM_RULE_ID).
- FIFO_DEPTH, 4, entries per input FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the positive edge.
- reset  in  1  asynchronous, active-high reset.
- sip_valid  in  1  sip_set is valid this cycle.
- sip_set  in  [0:NUM_RULE_ID*(1+RULE_ID_WIDTH)-1]  SIP rule ID set.
- dip_valid  in  1  dip_set is valid this cycle.
- dip_set  in  same width as sip_set  DIP rule ID set.
- out_valid  out  1  out_set and out_match_* are valid this cycle.
- out_set  out  same width as sip_set  intersected rule ID set.
- out_match_valid  out  1  intersection is non-empty.
- out_match_id  out  RULE_ID_WIDTH  lowest rule ID in the intersection.
- sip_overflow  out  1  sticky; a SIP push was dropped.
- dip_overflow  out  1  sticky; a DIP push was dropped.

Behaviour:
- Set format:
  - Slot k occupies bits [4k:4k+3]: bit 4k is the slot valid bit, bits 4k+1..4k+3 are the ID (MSB first).
  - Valid slots are right-justified and hold ascending, distinct IDs.
  - Invalid slots are all-zero.
- Reset:
  - Asynchronous; takes effect immediately, including mid-operation.
  - All outputs go to 0, both FIFOs empty, pipeline valids cleared, overflow flags cleared.
  - In-flight data is discarded.
- Push:
  - On an edge with x_valid=1, x_set is written to FIFO x.
  - The write is accepted if the FIFO is not full, or if the FIFO is full and a pop occurs on the same edge.
  - Otherwise the push is dropped and x_overflow is set. It stays 1 until reset.
- Pop:
  - Both heads pop on the same edge only when both FIFOs are non-empty.
  - Heads are read combinationally from the registered FIFO storage.
  - Pairing is strictly first-in-first-out per field.
- Stage 1 (registered at the pop edge):
  - Decode each head into an NUM_RULE_ID-bit bitmap: bit r=1 iff some valid slot holds ID r.
  - Duplicate IDs are tolerated (ORed). Invalid slots are ignored regardless of their ID bits.
  - Register the bitwise AND of the two bitmaps, together with a valid bit.
- Stage 2 (outputs registered):
  - out_valid follows the stage-1 valid bit.
  - out_match_id is the index of the lowest set bit of the AND bitmap, and out_match_valid=1.
  - For an empty AND: out_match_valid=0, out_match_id=0, out_set=0, out_valid still 1.
  - out_set repacks the AND bitmap: ascending order, right-justified, with unused slots zero.
  - When out_valid=0, out_set, out_match_valid and out_match_id hold 0.
- Latency: exactly 2 clock edges from the edge that writes the later of a pair to out_valid=1, provided both FIFOs were otherwise empty.
- Throughput: one pair per cycle. There is no backpressure from downstream.
- Simultaneous push and pop on the same FIFO:
  - Occupancy is unchanged.
  - When the FIFO is empty, the new entry is not popped on that same edge (no bypass).
- Read and write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an occupancy counter of width log2(FIFO_DEPTH)+1.

Decomposition:
- Shared package rule_set_pkg:
  - Constants NUM_RULE_ID, RULE_ID_WIDTH, SLOT_WIDTH (=1+RULE_ID_WIDTH), SET_WIDTH.
  - Pure functions set_to_bitmap, bitmap_to_set and lowest_id.
  - The functions are reused by the DIP and port stages.
- Sub-module rule_set_fifo (SET_WIDTH wide, FIFO_DEPTH deep, async reset, push/pop/full/empty/head, overflow-drop rule above), instantiated once per field.

Test Plan:
- SIP 32'h0000ADEF {2,5,6,7} and DIP 32'h000000EF {6,7} pushed on the same edge -> 2 edges later out_valid=1, out_set=32'h000000EF, out_match_valid=1, out_match_id=6.
- SIP 32'h0089BDEF {0,1,3,5,6,7} (192.168.0.40) and DIP 32'h000009CD {1,4,5} -> out_set=32'h0000009D, out_match_id=1.
- SIP 32'h0000000A {2} and DIP 32'h0000000B {3} -> out_valid=1, out_set=0, out_match_valid=0, out_match_id=0.
- SIP pushes A, B, C on consecutive edges; DIP pushes A', B', C' starting 3 cycles later -> three consecutive outputs (A∩A', B∩B', C∩C'), each 2 edges after its DIP push; no overflow.
- FIFO_DEPTH=4: five SIP pushes and no DIP -> 5th dropped and sip_overflow=1. Then four DIP pushes -> four outputs paired with SIP 1-4; sip_overflow stays 1.
- Reset asserted mid-cycle while two pairs are in flight -> out_valid and outputs drop to 0 before the next edge. After release, no stale output appears and FIFOs are empty.
